// File: rtl/apb_master_rr_arbiter_pkg.sv
// Shared APB types: request/response bundles, arbiter FSM states, limits.
// Ports: none (package only).
package apb_types;

    localparam int APB_ARB_MAX_REQ = 8;
    localparam int APB_ARB_ID_W    = 3;

    typedef struct packed {
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
    } apb_request_t;

    typedef struct packed {
        logic        pready;
        logic        perr;
        logic [31:0] prdata;
    } apb_response_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_arb_fsm_state;

endpackage

// File: rtl/apb_master_rr_arbiter_if.sv
// Bus bundle for the round-robin APB arbiter: requester side, target side, status.
// Ports: req_* / resp_* (requesters), apb_request / apb_response (target), grant_id, timeout_pulse.
interface apb_master_rr_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import apb_types::*;

    logic [NUM_REQ-1:0]    req_psel;
    logic [NUM_REQ-1:0]    req_penable;
    logic [NUM_REQ-1:0]    req_pwrite;
    logic [32*NUM_REQ-1:0] req_paddr;
    logic [32*NUM_REQ-1:0] req_pwdata;
    logic [NUM_REQ-1:0]    resp_pready;
    logic [NUM_REQ-1:0]    resp_perr;
    logic [31:0]           resp_prdata;
    apb_request_t          apb_request;
    apb_response_t         apb_response;
    logic [2:0]            grant_id;
    logic                  timeout_pulse;

    // Arbiter's view.
    modport master (
        input  req_psel, req_penable, req_pwrite, req_paddr, req_pwdata,
        input  apb_response,
        output resp_pready, resp_perr, resp_prdata,
        output apb_request, grant_id, timeout_pulse
    );

    // Environment's view: requesters plus the target.
    modport slave (
        output req_psel, req_penable, req_pwrite, req_paddr, req_pwdata,
        output apb_response,
        input  resp_pready, resp_perr, resp_prdata,
        input  apb_request, grant_id, timeout_pulse
    );

endinterface

// File: rtl/apb_master_rr_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first set request after i_last_grant, with wrap.
// Ports: i_req (request vector), i_last_grant, o_valid (any request), o_winner (index).
module rr_priority_select
    import apb_types::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [2:0]         i_last_grant,
    output logic               o_valid,
    output logic [2:0]         o_winner
);

    logic [APB_ARB_MAX_REQ-1:0] w_req_pad;
    logic [3:0]                 w_pos;

    // Padding lets a 3-bit index address the vector for any NUM_REQ.
    assign w_req_pad = APB_ARB_MAX_REQ'(i_req);

    // Scan farthest-to-nearest so the nearest hit is the one left standing.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_pos    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_pos = {1'b0, i_last_grant} + 4'(k);
            if (w_pos >= 4'(NUM_REQ)) begin
                w_pos = w_pos - 4'(NUM_REQ);
            end
            if (w_req_pad[w_pos[2:0]]) begin
                o_valid  = 1'b1;
                o_winner = w_pos[2:0];
            end
        end
    end

endmodule

// File: rtl/apb_master_rr_arbiter.sv
// Round-robin arbiter sharing one APB target among NUM_REQ masters, with watchdog abort.
// Ports: clk, clk__enable, reset (async, active-high), bus (requesters, target, grant_id, timeout_pulse).
module apb_master_rr_arbiter
    import apb_types::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    clk__enable,
    input  logic                    reset,
    apb_master_rr_arbiter_if.master bus
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    apb_arb_fsm_state r_state;
    logic             r_psel;
    logic             r_penable;
    logic             r_pwrite;
    logic [31:0]      r_paddr;
    logic [31:0]      r_pwdata;
    logic [2:0]       r_grant_id;
    logic [2:0]       r_last_grant;
    logic [CW-1:0]    r_cnt;

    logic             w_valid;
    logic [2:0]       w_winner;
    logic             w_pwrite_sel;
    logic [31:0]      w_paddr_sel;
    logic [31:0]      w_pwdata_sel;
    logic             w_access;
    logic             w_ready;
    logic             w_expire;
    logic             w_done;
    logic             w_unused;

    // Requester penable is not needed: the target phase is generated here.
    assign w_unused = ^bus.req_penable;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ)
    ) u_sel (
        .i_req        (bus.req_psel),
        .i_last_grant (r_last_grant),
        .o_valid      (w_valid),
        .o_winner     (w_winner)
    );

    always_comb begin
        w_paddr_sel  = '0;
        w_pwdata_sel = '0;
        w_pwrite_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == 3'(i)) begin
                w_paddr_sel  = bus.req_paddr[32*i +: 32];
                w_pwdata_sel = bus.req_pwdata[32*i +: 32];
                w_pwrite_sel = bus.req_pwrite[i];
            end
        end
    end

    assign w_access = (r_state == ST_ACCESS);
    assign w_ready  = w_access & bus.apb_response.pready;
    // pready in the last allowed cycle takes precedence over the abort.
    assign w_expire = (TIMEOUT_CYCLES != 0) && w_access
                      && !bus.apb_response.pready
                      && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_done   = w_ready | w_expire;

    always_comb begin
        bus.resp_pready = '0;
        bus.resp_perr   = '0;
        bus.resp_prdata = '0;
        if (w_done) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_grant_id == 3'(i)) begin
                    bus.resp_pready[i] = 1'b1;
                    bus.resp_perr[i]   = w_expire | bus.apb_response.perr;
                end
            end
            bus.resp_prdata = w_ready ? bus.apb_response.prdata : '0;
        end
    end

    assign bus.timeout_pulse = w_expire;
    assign bus.grant_id      = r_grant_id;
    assign bus.apb_request   = '{psel:    r_psel,
                                 penable: r_penable,
                                 pwrite:  r_pwrite,
                                 paddr:   r_paddr,
                                 pwdata:  r_pwdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_grant_id   <= '0;
            r_last_grant <= 3'(NUM_REQ - 1);
            r_cnt        <= '0;
        end else if (clk__enable) begin
            unique case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_valid) begin
                        r_paddr      <= w_paddr_sel;
                        r_pwdata     <= w_pwdata_sel;
                        r_pwrite     <= w_pwrite_sel;
                        r_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        r_psel       <= 1'b1;
                        r_penable    <= 1'b0;
                        r_state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_rr_arbiter.sv
// Directed bench for apb_master_rr_arbiter with a grant-order scoreboard.
// Ports: none (top-level bench).
module tb_apb_master_rr_arbiter;
    import apb_types::*;

    localparam int NR  = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic clk__enable;
    logic reset;

    apb_master_rr_arbiter_if #(.NUM_REQ(NR)) bus();

    apb_master_rr_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .clk__enable (clk__enable),
        .reset       (reset),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic        perr;
        logic [31:0] rdata;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic write, input logic perr, input logic [31:0] rdata,
                           input logic tmo);
        exp_t e;
        bus.req_psel[id]             = 1'b1;
        bus.req_penable[id]          = 1'b0;
        bus.req_pwrite[id]           = write;
        bus.req_paddr[32*id +: 32]   = addr;
        bus.req_pwdata[32*id +: 32]  = wdata;
        e = '{id, addr, wdata, write, perr, rdata, tmo};
        sb.push_back(e);
    endtask

    // mode 0: drop psel at completion, 1: keep psel, 2: drop psel during setup
    task automatic run_txn(input int delay, input logic t_perr, input logic [31:0] t_rdata,
                           input int mode);
        exp_t e;
        bit   done;
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("idle_psel", bus.apb_request.psel, 0);
        tick();
        chk("setup_psel", bus.apb_request.psel, 1);
        chk("setup_penable", bus.apb_request.penable, 0);
        chk("grant_id", bus.grant_id, 64'(e.id));
        chk("setup_paddr", bus.apb_request.paddr, e.addr);
        chk("setup_pwdata", bus.apb_request.pwdata, e.wdata);
        chk("setup_pwrite", bus.apb_request.pwrite, e.write);
        chk("setup_rdy", bus.resp_pready, 0);
        bus.req_paddr[32*e.id +: 32]  = ~e.addr;
        bus.req_pwdata[32*e.id +: 32] = ~e.wdata;
        if (mode == 2) bus.req_psel[e.id] = 1'b0;
        done = 0;
        for (int k = 0; k < TMO && !done; k++) begin
            tick();
            bus.apb_response.pready = (k == delay);
            bus.apb_response.perr   = t_perr;
            bus.apb_response.prdata = t_rdata;
            #1;
            chk("acc_penable", bus.apb_request.penable, 1);
            chk("acc_paddr", bus.apb_request.paddr, e.addr);
            if (k == delay || k == TMO - 1) begin
                chk("resp_pready", bus.resp_pready, 64'd1 << e.id);
                chk("resp_perr", bus.resp_perr, 64'(e.perr) << e.id);
                chk("resp_prdata", bus.resp_prdata, e.rdata);
                chk("timeout_pulse", bus.timeout_pulse, e.tmo);
                done = 1;
                if (mode == 0) bus.req_psel[e.id] = 1'b0;
            end else begin
                chk("wait_pready", bus.resp_pready, 0);
                chk("wait_pulse", bus.timeout_pulse, 0);
            end
        end
        tick();
        bus.apb_response.pready = 1'b0;
        chk("post_psel", bus.apb_request.psel, 0);
        chk("post_pready", bus.resp_pready, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req_psel = '0;
        bus.apb_response = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        clk__enable      = 1'b1;
        bus.req_psel     = '0;
        bus.req_penable  = '0;
        bus.req_pwrite   = '0;
        bus.req_paddr    = '0;
        bus.req_pwdata   = '0;
        bus.apb_response = '0;
        repeat (2) tick();
        chk("rst_psel", bus.apb_request.psel, 0);
        chk("rst_penable", bus.apb_request.penable, 0);
        chk("rst_paddr", bus.apb_request.paddr, 0);
        chk("rst_grant", bus.grant_id, 0);
        chk("rst_pready", bus.resp_pready, 0);
        chk("rst_perr", bus.resp_perr, 0);
        chk("rst_prdata", bus.resp_prdata, 0);
        chk("rst_pulse", bus.timeout_pulse, 0);
        reset = 1'b0;

        // Single write
        set_req(0, 32'h1004, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
        run_txn(0, 1'b0, 32'h0, 0);

        // All four at once after reset
        do_reset();
        for (int i = 0; i < NR; i++)
            set_req(i, 32'h100 * (i + 1), 32'hA000_0000 + i, 1'(i % 2), 1'b0, 32'h11 * i, 1'b0);
        run_txn(0, 1'b0, 32'h00, 0);
        run_txn(1, 1'b0, 32'h11, 0);
        run_txn(2, 1'b0, 32'h22, 0);
        run_txn(0, 1'b0, 32'h33, 0);

        // Req1/req2 held, req3 joins after req1
        set_req(1, 32'h2010, 32'h1, 1'b1, 1'b0, 32'h0, 1'b0);
        set_req(2, 32'h2020, 32'h2, 1'b1, 1'b0, 32'h0, 1'b0);
        run_txn(0, 1'b0, 32'h0, 1);
        set_req(3, 32'h2030, 32'h3, 1'b1, 1'b0, 32'h0, 1'b0);
        run_txn(1, 1'b0, 32'h0, 1);
        set_req(1, 32'h2011, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0);
        run_txn(0, 1'b0, 32'h0, 0);
        set_req(2, 32'h2021, 32'h5, 1'b0, 1'b0, 32'h0, 1'b0);
        run_txn(0, 1'b0, 32'h0, 0);
        run_txn(0, 1'b0, 32'h0, 0);

        // Watchdog abort, then a normal grant, then pready on the last cycle
        set_req(0, 32'h3000, 32'h7, 1'b1, 1'b1, 32'h0, 1'b1);
        run_txn(-1, 1'b0, 32'hAAAA5555, 0);
        set_req(1, 32'h3004, 32'h8, 1'b0, 1'b0, 32'h0BADF00D, 1'b0);
        run_txn(2, 1'b0, 32'h0BADF00D, 0);
        set_req(2, 32'h3008, 32'h9, 1'b0, 1'b0, 32'h55, 1'b0);
        run_txn(TMO - 1, 1'b0, 32'h55, 0);

        // Read with target error while another requester waits
        set_req(3, 32'h4000, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0);
        set_req(0, 32'h4004, 32'hC, 1'b1, 1'b0, 32'h0, 1'b0);
        run_txn(1, 1'b1, 32'h12345678, 2);
        run_txn(0, 1'b0, 32'h0, 0);

        // Clock enable low holds the FSM in IDLE
        set_req(1, 32'h5000, 32'hD, 1'b1, 1'b0, 32'h0, 1'b0);
        clk__enable = 1'b0;
        tick();
        chk("cke_psel0", bus.apb_request.psel, 0);
        tick();
        chk("cke_psel1", bus.apb_request.psel, 0);
        chk("cke_grant", bus.grant_id, 0);
        clk__enable = 1'b1;
        run_txn(0, 1'b0, 32'h0, 0);

        // Reset in ACCESS
        bus.req_psel[2] = 1'b1;
        tick();
        tick();
        chk("pre_rst_penable", bus.apb_request.penable, 1);
        reset = 1'b1;
        #1;
        chk("async_psel", bus.apb_request.psel, 0);
        chk("async_penable", bus.apb_request.penable, 0);
        chk("async_pready", bus.resp_pready, 0);
        tick();
        reset = 1'b0;
        set_req(0, 32'h6000, 32'hE, 1'b1, 1'b0, 32'h0, 1'b0);
        set_req(2, 32'h6008, 32'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        run_txn(0, 1'b0, 32'h0, 0);
        run_txn(0, 1'b0, 32'h0, 0);

        chk("sb_empty", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
